regfile_wr_32x32: RTL and testbench
===================================

Name: regfile_wr_32x32

Overview:
Write side of the 32-entry general-purpose register file. It decodes a 5-bit write select into one of 32 word registers and stores the write data on the clock edge. It presents all 32 register words as a flat bus that feeds the 32-to-1 read-select muxes. Register 0 is optionally hardwired to zero. The block also returns a one-cycle write acknowledge and a drop indication to the writeback stage.

Parameters:
WIDTH, 32, bits per register word
ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes; 0 = register 0 is ordinary storage

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
wr_en  input  1  write request, sampled on rising clk
wr_sel  input  5  destination register index 0..31
wr_data  input  WIDTH  data to store
q_flat  output  32*WIDTH  all register words; register k at bits [k*WIDTH +: WIDTH]
wr_ack  output  1  registered pulse: the previous cycle's write was committed
wr_drop  output  1  registered pulse: the previous cycle's write targeted register 0 with ZERO_REG=1 and was discarded
last_sel  output  5  index of the most recently committed register

Behaviour:
- Reset: rst_n low forces the following immediately, without waiting for clk:
  - all 32 registers to 0, so q_flat = 0;
  - wr_ack = 0, wr_drop = 0, last_sel = 0.
- Reset is asynchronous on assertion. Deassertion is taken synchronously by the surrounding reset synchronizer; this block needs no logic for it.
- Decode: one-hot enable, en[k] = wr_en & (wr_sel == k). Exactly one register is enabled per cycle when wr_en=1.
- Commit: on a rising clk with wr_en=1, register wr_sel takes wr_data, unless wr_sel=0 and ZERO_REG=1.
- Hold: registers not selected hold their value. With wr_en=0, nothing changes.
- Write latency: the new value appears on q_flat after the same rising edge that sampled the write. There is no internal bypass. A read mux driven from q_flat in the same cycle as the write sees the old value.
- Register 0 with ZERO_REG=1: its storage is omitted and q_flat[WIDTH-1:0] is a constant 0.
- Registered status, updated every rising clk:
  - wr_ack <= wr_en & ~(ZERO_REG & wr_sel==0)
  - wr_drop <= wr_en & ZERO_REG & (wr_sel==0)
  - last_sel <= wr_sel when the write commits; otherwise it holds.
- Status relations:
  - wr_ack and wr_drop are never both 1.
  - Each is a single-cycle pulse per request.
  - Back-to-back writes produce back-to-back pulses.
- Repeat writes: consecutive writes to the same register take the last value written. Each write still pulses wr_ack.
- Reset in the middle of a stream: reset asserted in the same cycle as wr_en=1 discards the write. No ack is produced after reset releases.
- Unknown select: wr_sel containing X/Z while wr_en=1 is a protocol violation. Simulation asserts; synthesis behaviour is undefined.
- Widths: no arithmetic. wr_data is stored as-is, with no sign or zero extension.
- Implementation: 32 register words in a generate loop plus the decoder and status flops. The reset value is a parameter-independent 0.

Test Plan:
- Reset check: apply rst_n=0 mid-cycle after loading values → q_flat, wr_ack, wr_drop and last_sel all become 0 immediately, without waiting for a clock edge.
- Full sweep: write reg k with data 0xA5A50000+k for k=1..31 on consecutive cycles →
  - each word reads its value the cycle after its write;
  - wr_ack is high for 31 consecutive cycles;
  - last_sel = 31 at the end.
- Zero register, ZERO_REG=1: write 0xDEADBEEF to sel 0 → q_flat[31:0] stays 0, wr_drop pulses once, wr_ack=0, last_sel unchanged. Repeat with ZERO_REG=0 → reg 0 = 0xDEADBEEF and wr_ack pulses.
- Isolation: preload all registers with 0x11111111, then write 0xFFFFFFFF to reg 17 → only bits [575:544] change; all other words remain 0x11111111.
- Same-register repeat and idle: write reg 5 with 0x1, 0x2, 0x3 back-to-back, then hold wr_en=0 for 4 cycles → reg 5 = 0x3, three wr_ack pulses, and no change while idle.
- Reset during write: assert rst_n=0 in the cycle wr_en=1, sel=9, data=0x12345678 → after release, reg 9 = 0 and no wr_ack pulse occurs.

Source files
------------

// File: rtl/regfile_wr_32x32.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | regfile_wr_32x32                                                       |
// | Write side of the 32-entry register file: one-hot decode, 32 words,    |
// | flat read bus, registered write ack/drop status.                       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module regfile_wr_32x32 #(
  parameter int WIDTH    = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [4:0]            wr_sel,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [32*WIDTH-1:0]   q_flat,
  output logic                  wr_ack,
  output logic                  wr_drop,
  output logic [4:0]            last_sel
);

  localparam int c_NREG = 32;

  logic       w_zero_hit;
  logic       w_commit;
  logic       r_ack;
  logic       r_drop;
  logic [4:0] r_last_sel;

  assign w_zero_hit = ZERO_REG && (wr_sel == 5'd0);
  assign w_commit   = wr_en && !w_zero_hit;

  generate
    for (genvar k = 0; k < c_NREG; k++) begin : g_reg
      if (ZERO_REG && k == 0) begin : g_zero
        // No storage: word 0 is a constant zero.
        assign q_flat[k*WIDTH +: WIDTH] = '0;
      end else begin : g_store
        logic             w_en;
        logic [WIDTH-1:0] r_word;

        assign w_en = wr_en && (wr_sel == 5'(k));

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_word <= '0;
          end else if (w_en) begin
            r_word <= wr_data;
          end
        end

        assign q_flat[k*WIDTH +: WIDTH] = r_word;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack      <= 1'b0;
      r_drop     <= 1'b0;
      r_last_sel <= 5'd0;
    end else begin
      r_ack  <= w_commit;
      r_drop <= wr_en && w_zero_hit;
      if (w_commit) begin
        r_last_sel <= wr_sel;
      end
    end
  end

  assign wr_ack   = r_ack;
  assign wr_drop  = r_drop;
  assign last_sel = r_last_sel;

`ifndef SYNTHESIS
  a_sel_known: assert property (@(posedge clk) disable iff (!rst_n)
    wr_en |-> !$isunknown(wr_sel));
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_32x32.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_regfile_wr_32x32                                                    |
// | Scoreboard bench driving ZERO_REG=1 and ZERO_REG=0 instances together. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_regfile_wr_32x32;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [4:0]    wr_sel;
  logic [31:0]   wr_data;
  logic [1023:0] q1, q0;
  logic          ack1, drop1, ack0, drop0;
  logic [4:0]    sel1, sel0;

  regfile_wr_32x32 #(.WIDTH(32), .ZERO_REG(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .q_flat(q1), .wr_ack(ack1), .wr_drop(drop1), .last_sel(sel1)
  );

  regfile_wr_32x32 #(.WIDTH(32), .ZERO_REG(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .q_flat(q0), .wr_ack(ack0), .wr_drop(drop0), .last_sel(sel0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1023:0] q1;
    logic [1023:0] q0;
    logic          a1, d1, a0, d0;
    logic [4:0]    s1, s0;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [1023:0] m1, m0;
  logic          ma1, md1, ma0, md0;
  logic [4:0]    ms1, ms0;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    tests++;
    assert (obs === exp) else begin
      int bad;
      bad = 0;
      for (int k = 31; k >= 0; k--)
        if (obs[k*32 +: 32] !== exp[k*32 +: 32]) bad = k;
      fails++;
      $error("FAIL %s word %0d observed=%h expected=%h", tag, bad,
             obs[bad*32 +: 32], exp[bad*32 +: 32]);
    end
  endtask

  task automatic model_reset();
    m1 = '0; m0 = '0;
    ma1 = 0; md1 = 0; ma0 = 0; md0 = 0;
    ms1 = '0; ms0 = '0;
  endtask

  task automatic check_now(input string tag);
    chk_q({tag, "_q1"}, q1, m1);
    chk_q({tag, "_q0"}, q0, m0);
    chk({tag, "_ack1"},  32'(ack1),  32'(ma1));
    chk({tag, "_drop1"}, 32'(drop1), 32'(md1));
    chk({tag, "_sel1"},  32'(sel1),  32'(ms1));
    chk({tag, "_ack0"},  32'(ack0),  32'(ma0));
    chk({tag, "_drop0"}, 32'(drop0), 32'(md0));
    chk({tag, "_sel0"},  32'(sel0),  32'(ms0));
  endtask

  // One clock of stimulus: drive at negedge, push expectation, compare after posedge.
  task automatic step(input string tag, input logic en, input logic [4:0] sel, input logic [31:0] data);
    exp_t e;
    @(negedge clk);
    wr_en = en; wr_sel = sel; wr_data = data;
    #1;
    chk_q({tag, "_nobypass1"}, q1, m1);
    chk_q({tag, "_nobypass0"}, q0, m0);
    if (en) begin
      if (sel != 5'd0) begin
        m1[sel*32 +: 32] = data; ma1 = 1; md1 = 0; ms1 = sel;
      end else begin
        ma1 = 0; md1 = 1;
      end
      m0[sel*32 +: 32] = data; ma0 = 1; md0 = 0; ms0 = sel;
    end else begin
      ma1 = 0; md1 = 0; ma0 = 0; md0 = 0;
    end
    e.q1 = m1; e.q0 = m0; e.a1 = ma1; e.d1 = md1; e.a0 = ma0; e.d0 = md0;
    e.s1 = ms1; e.s0 = ms0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    tests++;
    assert (sb.size() != 0) else begin
      fails++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk_q({tag, "_q1"}, q1, e.q1);
      chk_q({tag, "_q0"}, q0, e.q0);
      chk({tag, "_ack1"},  32'(ack1),  32'(e.a1));
      chk({tag, "_drop1"}, 32'(drop1), 32'(e.d1));
      chk({tag, "_sel1"},  32'(sel1),  32'(e.s1));
      chk({tag, "_ack0"},  32'(ack0),  32'(e.a0));
      chk({tag, "_drop0"}, 32'(drop0), 32'(e.d0));
      chk({tag, "_sel0"},  32'(sel0),  32'(e.s0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_en = 0; wr_sel = '0; wr_data = '0;
    rst_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #2 check_now("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 1; k < 32; k++)
      step("sweep", 1'b1, 5'(k), 32'hA5A50000 + 32'(k));

    step("zero_wr", 1'b1, 5'd0, 32'hDEADBEEF);
    step("zero_idle", 1'b0, 5'd0, 32'h0);

    for (int k = 0; k < 32; k++)
      step("preload", 1'b1, 5'(k), 32'h11111111);
    step("iso17", 1'b1, 5'd17, 32'hFFFFFFFF);

    step("rep1", 1'b1, 5'd5, 32'h1);
    step("rep2", 1'b1, 5'd5, 32'h2);
    step("rep3", 1'b1, 5'd5, 32'h3);
    for (int i = 0; i < 4; i++)
      step("idle", 1'b0, 5'd5, 32'hFFFF0000);

    // Asynchronous reset mid-cycle while a write is being presented
    @(negedge clk);
    wr_en = 1'b1; wr_sel = 5'd9; wr_data = 32'h12345678;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_now("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    wr_en = 1'b0;
    step("post_rst", 1'b0, 5'd9, 32'h0);
    step("recover", 1'b1, 5'd9, 32'hCAFEF00D);
    step("tail", 1'b0, 5'd0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
